fetch_stage: RTL and testbench

//   Instruction-fetch stage with the IF/ID pipeline register. Keeps the PC and issues

---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Keeps the PC and
//   issues one request at a time to a variable-latency instruction memory. If
//   decode is stalled when a word comes back, that word waits in a one-entry
//   skid buffer. Branch redirects from execute flush IF/ID and cancel any fetch
//   that is in flight or buffered.
//
// Parameters
//   RESET_PC        PC fetched first after reset
//   NOP_INST        bubble encoding loaded into IF/ID on flush or bubble
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             synchronous active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch address (word aligned)
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  instruction word returned this cycle
//   imem_rsp_data   returned instruction word
//   stall           decode does not consume IF/ID this cycle
//   redirect_valid  taken branch/jump: flush and refetch
//   redirect_pc     redirect target; bits [1:0] are forced to zero
//   if_id_valid     IF/ID holds a real instruction
//   if_id_pc        PC of if_id_inst
//   if_id_pc4       if_id_pc + 4, modulo 2^32
//   if_id_inst      instruction to decode / immediate generator
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] req_pc_q;
    logic [31:0] skid_q;
    logic [31:0] redir_tgt;
    logic        accept;
    logic        if_id_free;
    logic        load_rsp;
    logic        load_skid;
    logic        capture_skid;

    assign redir_tgt      = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid = (state_q == S_REQ) & ~redirect_valid & ~rst;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid & imem_req_ready;
    assign if_id_free     = ~stall | ~if_id_valid;

    // ---- fetch control: next state, next PC, IF/ID load selects ----
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load_rsp     = 1'b0;
        load_skid    = 1'b0;
        capture_skid = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end else if (accept) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (redirect_valid) begin
                        pc_d = redir_tgt;
                    end else if (if_id_free) begin
                        load_rsp = 1'b1;
                    end else begin
                        capture_skid = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Response still owed by memory; swallow it in DROP.
                    pc_d    = redir_tgt;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = S_REQ;
                end else if (!stall) begin
                    load_skid = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // req_pc and skid are pure data: only meaningful while WAIT/HOLD track them.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc_q <= pc_q;
        end
        if (capture_skid) begin
            skid_q <= imem_rsp_data;
        end
    end

    // ---- IF/ID pipeline register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_inst  <= NOP_INST;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end else if (stall && if_id_valid) begin
            if_id_valid <= if_id_valid;
        end else if (load_rsp) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= req_pc_q;
            if_id_inst  <= imem_rsp_data;
        end else if (load_skid) begin
            // No request is issued in HOLD, so req_pc still names the skid word.
            if_id_valid <= 1'b1;
            if_id_pc    <= req_pc_q;
            if_id_inst  <= skid_q;
        end else begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end
    end

    assign if_id_pc4 = if_id_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr_a, req_addr_b;
    logic        ifv_a, ifv_b;
    logic [31:0] ifpc_a, ifpc_b, ifpc4_a, ifpc4_b, ifinst_a, ifinst_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut_a (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_a), .imem_req_addr(req_addr_a),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(ifv_a), .if_id_pc(ifpc_a), .if_id_pc4(ifpc4_a), .if_id_inst(ifinst_a)
    );

    // Wrap-around instance; only checked over the first transaction.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_b), .imem_req_addr(req_addr_b),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(ifv_b), .if_id_pc(ifpc_b), .if_id_pc4(ifpc4_b), .if_id_inst(ifinst_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, ifv_a}, {31'd0, v});
        chk({tag, "_inst"}, ifinst_a, inst);
        if (v) begin
            chk({tag, "_pc"}, ifpc_a, pc);
            chk({tag, "_pc4"}, ifpc4_a, pc + 32'd4);
        end
    endtask

    task automatic req(input string tag, input logic v, input logic [31:0] addr);
        chk({tag, "_reqv"}, {31'd0, req_valid_a}, {31'd0, v});
        if (v) chk({tag, "_addr"}, req_addr_a, addr);
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        // Reset for two cycles
        tick(); tick();
        #1;
        chk("rst_valid", {31'd0, ifv_a}, 32'd0);
        chk("rst_pc", ifpc_a, 32'd0);
        chk("rst_pc4", ifpc4_a, 32'd4);
        chk("rst_inst", ifinst_a, NOP);
        chk("rst_reqv", {31'd0, req_valid_a}, 32'd0);

        // Test 1: 1-cycle memory returning address as data
        rst = 1'b0; #1;
        req("t1_c0", 1'b1, 32'h0);
        chk("t5_first_addr", req_addr_b, 32'hFFFF_FFFC);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0; #1;
        req("t1_c1_wait", 1'b0, 32'h0);
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t1_if0", 1'b1, 32'h0, 32'h0);
        req("t1_c2", 1'b1, 32'h4);
        chk("t5_ifpc", ifpc_b, 32'hFFFF_FFFC);
        chk("t5_ifpc4", ifpc4_b, 32'h0);
        chk("t5_next_addr", req_addr_b, 32'h0);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4; #1;
        ifid("t1_bubble", 1'b0, 32'h0, NOP);
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t1_if4", 1'b1, 32'h4, 32'h4);
        req("t1_c4", 1'b1, 32'h8);

        // Test 2: stall while response for pc 8 arrives -> HOLD
        stall = 1'b1; #1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8; #1;
        ifid("t2_hold_a", 1'b1, 32'h4, 32'h4);
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t2_hold_b", 1'b1, 32'h4, 32'h4);
        req("t2_hold_b", 1'b0, 32'h0);
        tick(); #1;
        ifid("t2_hold_c", 1'b1, 32'h4, 32'h4);
        req("t2_hold_c", 1'b0, 32'h0);
        stall = 1'b0;
        tick(); #1;
        ifid("t2_release", 1'b1, 32'h8, 32'h8);
        req("t2_norefetch", 1'b1, 32'hC);

        // Test 3: redirect while waiting on pc 0x10
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hC; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t3_ifC", 1'b1, 32'hC, 32'hC);
        req("t3_c0", 1'b1, 32'h10);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #1;
        req("t3_redir", 1'b0, 32'h0);
        tick();
        redirect_valid = 1'b0; #1;
        ifid("t3_flush", 1'b0, 32'h0, NOP);
        req("t3_drop", 1'b0, 32'h0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h10;
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t3_discard", 1'b0, 32'h0, NOP);
        req("t3_target", 1'b1, 32'h100);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0ABC; #1;
        ifid("t3_wait", 1'b0, 32'h0, NOP);
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t3_if100", 1'b1, 32'h100, 32'h0000_0ABC);
        req("t3_next", 1'b1, 32'h104);

        // Test 4: redirect and stall together while a word sits in the skid
        stall = 1'b1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55; #1;
        tick();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        ifid("t4_held", 1'b1, 32'h100, 32'h0000_0ABC);
        tick();
        redirect_valid = 1'b0; stall = 1'b0; #1;
        ifid("t4_flush", 1'b0, 32'h0, NOP);
        req("t4_target", 1'b1, 32'h200);
        tick(); #1;
        ifid("t4_skid_gone", 1'b0, 32'h0, NOP);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h77;
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t4_if200", 1'b1, 32'h200, 32'h77);

        // Test 6: reset in WAIT with a response the same cycle
        tick();
        rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h99; #1;
        chk("t6_reqv_rst", {31'd0, req_valid_a}, 32'd0);
        tick();
        rst = 1'b0; imem_rsp_valid = 1'b0; #1;
        ifid("t6_after_rst", 1'b0, 32'h0, NOP);
        chk("t6_ifpc", ifpc_a, 32'h0);
        req("t6_first", 1'b1, 32'h0);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("t6_if0", 1'b1, 32'h0, 32'h11);

        // Memory not ready: request held at the same address
        imem_req_ready = 1'b0; #1;
        tick(); #1;
        req("nr_hold", 1'b1, 32'h4);
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h44; #1;
        tick();
        imem_rsp_valid = 1'b0; #1;
        ifid("nr_if4", 1'b1, 32'h4, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
